// File: rtl/counter_4bit.sv
// Free-running modulo-(MAX_VAL+1) up-counter with enable and a registered wrap pulse.
// Both outputs come straight from flops, so this block can be cascaded without adding combinational depth.
module counter_4bit #(
    parameter int unsigned           WIDTH   = 4,
    parameter logic [WIDTH-1:0]      MAX_VAL = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic [WIDTH-1:0] counter,
    output logic             wrap
);

    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_next_s;
    logic             wrap_r;
    logic             wrap_next_s;
    logic             at_max_s;

    assign at_max_s = (count_r == MAX_VAL);

    // Next count and wrap: enable advances the count and folds MAX_VAL back to zero; otherwise the count holds.
    always_comb begin
        count_next_s = count_r;
        wrap_next_s  = 1'b0;
        if (enable) begin
            if (at_max_s) begin
                count_next_s = {WIDTH{1'b0}};
                wrap_next_s  = 1'b1;
            end else begin
                count_next_s = count_r + WIDTH'(1'b1);
                wrap_next_s  = 1'b0;
            end
        end else begin
            count_next_s = count_r;
            wrap_next_s  = 1'b0;
        end
    end

    // State register; reset overrides any pending count or wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= {WIDTH{1'b0}};
            wrap_r  <= 1'b0;
        end else begin
            count_r <= count_next_s;
            wrap_r  <= wrap_next_s;
        end
    end

    assign counter = count_r;
    assign wrap    = wrap_r;

endmodule

// File: tb/tb_counter_4bit.sv
// Bench for counter_4bit: a full-range instance and a MAX_VAL=9 instance driven in lockstep,
// each compared every cycle against an arithmetic reference model.
module tb_counter_4bit;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [3:0] counter_a;
    logic       wrap_a;
    logic [3:0] counter_b;
    logic       wrap_b;

    int total;
    int bad;
    int exp_a;
    int exp_b;
    int exp_wrap_a;
    int exp_wrap_b;
    int wraps_a;
    int wraps_b;

    counter_4bit dut_a (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .counter (counter_a),
        .wrap    (wrap_a)
    );

    counter_4bit #(.WIDTH(4), .MAX_VAL(4'd9)) dut_b (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .counter (counter_b),
        .wrap    (wrap_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Model: counts modulo max+1 from the spec's rules, reset first, then enable, then hold.
    task automatic model(input logic r, input logic e, input int max_val, inout int cnt, inout int wr);
        if (r) begin
            cnt = 0;
            wr  = 0;
        end else if (e) begin
            wr  = (cnt == max_val) ? 1 : 0;
            cnt = (cnt + 1) % (max_val + 1);
        end else begin
            wr = 0;
        end
    endtask

    task automatic step(input logic r, input logic e);
        @(negedge clk);
        reset  = r;
        enable = e;
        @(posedge clk);
        model(r, e, 15, exp_a, exp_wrap_a);
        model(r, e, 9, exp_b, exp_wrap_b);
        #1;
        chk("cnt_a", {28'd0, counter_a}, exp_a);
        chk("wrap_a", {31'd0, wrap_a}, exp_wrap_a);
        chk("cnt_b", {28'd0, counter_b}, exp_b);
        chk("wrap_b", {31'd0, wrap_b}, exp_wrap_b);
        chk("range_b", {31'd0, (counter_b <= 4'd9)}, 32'd1);
        if (wrap_a === 1'b1) wraps_a++;
        if (wrap_b === 1'b1) wraps_b++;
    endtask

    initial begin
        total = 0;
        bad = 0;
        exp_a = 0;
        exp_b = 0;
        exp_wrap_a = 0;
        exp_wrap_b = 0;
        reset = 1'b0;
        enable = 1'b0;

        // Reset then count to 10
        step(1'b1, 1'b0);
        chk("reset_cnt", {28'd0, counter_a}, 32'd0);
        chk("reset_wrap", {31'd0, wrap_a}, 32'd0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1);
        chk("count_to_10", {28'd0, counter_a}, 32'd10);

        // Hold for 5, then resume
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0);
            chk("hold_10", {28'd0, counter_a}, 32'd10);
        end
        step(1'b0, 1'b1);
        chk("resume_11", {28'd0, counter_a}, 32'd11);
        step(1'b0, 1'b1);
        chk("resume_12", {28'd0, counter_a}, 32'd12);

        // Reset priority at 7
        step(1'b1, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1);
        chk("at_7", {28'd0, counter_a}, 32'd7);
        step(1'b1, 1'b1);
        chk("rst_prio_cnt", {28'd0, counter_a}, 32'd0);
        chk("rst_prio_wrap", {31'd0, wrap_a}, 32'd0);
        step(1'b0, 1'b1);
        chk("after_rst_1", {28'd0, counter_a}, 32'd1);

        // Reset while holding at 5
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        chk("hold_5", {28'd0, counter_a}, 32'd5);
        step(1'b1, 1'b0);
        chk("rst_hold_0", {28'd0, counter_a}, 32'd0);
        step(1'b1, 1'b1);
        chk("rst_en_0", {28'd0, counter_a}, 32'd0);
        step(1'b1, 1'b0);
        chk("rst_stay_0", {28'd0, counter_a}, 32'd0);

        // Wrap: 17 enables after reset; reset at MAX_VAL gives no wrap
        wraps_a = 0;
        wraps_b = 0;
        for (int i = 0; i < 17; i++) step(1'b0, 1'b1);
        chk("wrap_seq_end", {28'd0, counter_a}, 32'd1);
        chk("wrap_count_a", wraps_a, 32'd1);
        chk("wrap_count_b17", wraps_b, 32'd1);
        for (int i = 0; i < 14; i++) step(1'b0, 1'b1);
        chk("at_max", {28'd0, counter_a}, 32'd15);
        step(1'b1, 1'b1);
        chk("rst_at_max_wrap", {31'd0, wrap_a}, 32'd0);
        chk("rst_at_max_cnt", {28'd0, counter_a}, 32'd0);

        // MAX_VAL=9 continuously enabled: one wrap per 10 cycles
        wraps_b = 0;
        for (int i = 0; i < 30; i++) step(1'b0, 1'b1);
        chk("wrap_count_b30", wraps_b, 32'd3);
        chk("b_after_30", {28'd0, counter_b}, 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
